// File: rtl/svnet_fifo_reader_pkg.sv
// Shared types and counter-width helpers for the svnet FIFO read-side packer.
// Used by svnet_fifo_reader and svnet_fifo_reader_packer.
package svnet_fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } svnet_fifo_reader_state_t;

  localparam int SVNET_FIFO_READER_STATE_W = 2;

  function automatic int lane_cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic int beat_cnt_w(input int ratio, input int burst);
    return (ratio * burst > 1) ? $clog2(ratio * burst) : 1;
  endfunction

endpackage

// File: rtl/svnet_fifo_reader_packer.sv
// Lane packer: collects RATIO narrow words into one wide word, first word in the low lane.
// flush_pad closes a partial word early; the unfilled upper lanes stay zero.
module svnet_fifo_reader_packer
  import svnet_fifo_reader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   shift,
  input  logic                   flush_pad,
  input  logic [WIDTH-1:0]       data,
  output logic [WIDTH*RATIO-1:0] word,
  output logic                   word_done
);

  localparam int LW = lane_cnt_w(RATIO);

  logic [LW-1:0]          lane_cnt_p0;
  logic [WIDTH*RATIO-1:0] lanes_p0;
  logic [WIDTH*RATIO-1:0] merged;
  logic                   last;

  always_comb begin
    merged = lanes_p0;
    merged[lane_cnt_p0*WIDTH +: WIDTH] = data;
    last = shift && ((lane_cnt_p0 == LW'(RATIO - 1)) || flush_pad);
  end

  // p0 -> p1: lanes are cleared as a word leaves, which provides the zero padding
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_cnt_p0 <= '0;
      lanes_p0    <= '0;
      word        <= '0;
      word_done   <= 1'b0;
    end else begin
      word_done <= last;
      if (shift) begin
        if (last) begin
          word        <= merged;
          lanes_p0    <= '0;
          lane_cnt_p0 <= '0;
        end else begin
          lanes_p0    <= merged;
          lane_cnt_p0 <= lane_cnt_p0 + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/svnet_fifo_reader.sv
// Read-side master: drains an upstream svnet FIFO in fixed bursts and writes packed wide words.
// Optional tail flush (extra port flush) enabled by defining SVNET_FIFO_READER_FLUSH_EN.
module svnet_fifo_reader
  import svnet_fifo_reader_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RATIO     = 4,
  parameter int BURST     = 2,
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
`ifdef SVNET_FIFO_READER_FLUSH_EN
  input  logic                           flush,
`endif
  input  logic [$clog2(IN_DEPTH):0]      in_used_space,
  input  logic [WIDTH-1:0]               in_read_data,
  output logic                           in_read,
  input  logic [$clog2(OUT_DEPTH):0]     out_free_space,
  output logic                           out_write,
  output logic [WIDTH*RATIO-1:0]         out_write_data,
  output logic                           busy
);

  localparam int BEATS = RATIO * BURST;
  localparam int UW    = $clog2(IN_DEPTH) + 1;
  localparam int FW    = $clog2(OUT_DEPTH) + 1;
  localparam int BCW   = beat_cnt_w(RATIO, BURST);

  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $error("svnet_fifo_reader: RATIO must be a power of two >= 2");
  end
  if (BURST < 1) begin : g_bad_burst
    $error("svnet_fifo_reader: BURST must be >= 1");
  end
  if (IN_DEPTH < BEATS) begin : g_bad_in_depth
    $error("svnet_fifo_reader: IN_DEPTH must be >= RATIO*BURST");
  end
  if (OUT_DEPTH < BURST) begin : g_bad_out_depth
    $error("svnet_fifo_reader: OUT_DEPTH must be >= BURST");
  end

  svnet_fifo_reader_state_t state_q;
  logic [BCW-1:0]           beat_cnt_q;
  logic                     flush_q;
  logic                     start_run;
  logic                     last_beat;
  logic                     flush_go;
  logic [BCW-1:0]           flush_beats;
  logic                     flush_pad;

  // Both FIFOs report registered status, so a burst is only launched once the
  // whole burst's data and space are guaranteed; nothing can stall it mid-way.
  assign start_run = (in_used_space >= UW'(BEATS)) && (out_free_space >= FW'(BURST));
  assign last_beat = (beat_cnt_q == '0);
  assign in_read   = rst_n && (state_q == RUN);
  assign busy      = (state_q != IDLE);

`ifdef SVNET_FIFO_READER_FLUSH_EN
  int fit_words;
  int n_words;

  always_comb begin
    fit_words   = RATIO * ((int'(out_free_space) >= BURST) ? BURST : int'(out_free_space));
    n_words     = (int'(in_used_space) < fit_words) ? int'(in_used_space) : fit_words;
    flush_go    = flush && (in_used_space != '0) && (out_free_space != '0);
    flush_beats = BCW'(n_words - 1);
  end
`else
  assign flush_go    = 1'b0;
  assign flush_beats = '0;
`endif

  assign flush_pad = flush_q && last_beat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      flush_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_run) begin
            state_q    <= RUN;
            beat_cnt_q <= BCW'(BEATS - 1);
            flush_q    <= 1'b0;
          end else if (flush_go) begin
            state_q    <= RUN;
            beat_cnt_q <= flush_beats;
            flush_q    <= 1'b1;
          end
        end
        RUN: begin
          if (last_beat) begin
            state_q <= DRAIN;
          end else begin
            beat_cnt_q <= beat_cnt_q - 1'b1;
          end
        end
        DRAIN: begin
          state_q <= IDLE;
          flush_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  svnet_fifo_reader_packer #(
    .WIDTH (WIDTH),
    .RATIO (RATIO)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift     (in_read),
    .flush_pad (flush_pad),
    .data      (in_read_data),
    .word      (out_write_data),
    .word_done (out_write)
  );

  a_read_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
    in_read |-> (in_used_space != '0));
  a_write_has_space: assert property (@(posedge clk) disable iff (!rst_n)
    out_write |-> (out_free_space != '0));

  final begin
    a_final_idle: assert (state_q == IDLE);
  end

endmodule
